rob_dual_commit: RTL and testbench
==================================

// Module: rob_dual_commit
// PURPOSE
//  Parametrised reorder buffer: circular queue of DEPTH in-flight instructions, allocated in order by the dispatcher.
//  Completed out of order by two CDB write-back channels (ALU, load/store).
//  Retires up to two ready head entries per cycle to the register file, and flushes the pipeline on a taken branch or jump.
//  Sits between dispatcher, CDB, RegFile, LSB and IF redirect logic.
// PARAMETERS
//  DEPTH        16  entries, power of two >= 4
//  IDX_W        4   log2(DEPTH); entry id width
//  DATA_W       32  result width
//  ADDR_W       32  pc width
//  REG_W        5   architectural register index width
//  FULL_MARGIN  2   full_dp_out asserted when free slots <= FULL_MARGIN
// PORTS
//  clk_in          in   1           clock
//  rst_in          in   1           async active-high reset
//  rdy_in          in   1           global enable; state frozen when low
//  alloc_dp_in     in   1           allocate one entry at tail this cycle
//  op_type_dp_in   in   3           0 ARITH, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP
//  dest_dp_in      in   REG_W       destination register
//  full_dp_out     out  1           no allocation permitted
//  rob_id_dp_out   out  IDX_W       id given to the current allocation (= tail)
//  rs1_id_dp_in, rs2_id_dp_in   in  IDX_W  operand producer ids
//  rs1_rdy_dp_out, rs2_rdy_dp_out  out  1  producer value available
//  rs1_val_dp_out, rs2_val_dp_out  out  DATA_W  producer value
//  wb_a_vld_in / wb_a_id_in / wb_a_val_in / wb_a_pc_in   in  1/IDX_W/DATA_W/ADDR_W  ALU write-back
//  wb_ls_vld_in / wb_ls_id_in / wb_ls_val_in   in  1/IDX_W/DATA_W  load/store write-back
//  cm0_vld_out, cm1_vld_out  out  1  register commit lane 0 / lane 1
//  cm0_dest_out, cm1_dest_out  out  REG_W  commit destination
//  cm0_val_out, cm1_val_out  out  DATA_W  commit value
//  cm0_id_out, cm1_id_out  out  IDX_W  committing entry id (RegFile tag clear)
//  head_id_lsb_out  out  IDX_W  current head id (LSB store release)
//  flush_out       out  1           pipeline flush, one cycle
//  new_pc_if_out   out  ADDR_W      redirect target, valid with flush_out
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all valid/ready bits 0.
//    All cm*_vld_out, flush_out = 0; data outputs 0.
//  - count is IDX_W+1 bits; full_dp_out = (DEPTH-count) <= FULL_MARGIN, combinational.
//  - Alloc when alloc_dp_in && !flush_out: entry[tail] valid=1, ready=0.
//    tail wraps DEPTH-1 -> 0. Alloc while full is a protocol error; ignore it.
//  - Write-back: sets ready and stores val (ALU also stores pc).
//    LS write-back stores val only for LOAD entries.
//    Write-back to an invalid entry is ignored. Both channels same cycle to different ids: both take effect.
//  - Operand lookup, combinational: rdy = entry ready OR same-cycle write-back hit on that id.
//    A write-back hit forwards the CDB value; ALU channel wins if both hit.
//  - Commit (outputs registered, 1-cycle latency): lane0 fires if head valid && ready.
//    lane1 fires if lane0 fired, lane0 is not a redirect, head+1 valid && ready, and not both entries are STORE.
//    cmN_vld_out=1 only for ARITH, LOAD, JUMP; STORE and BRANCH retire silently.
//    Commit clears entry valid/ready; head advances by the number retired (mod DEPTH).
//  - Redirect: committing JUMP, or BRANCH with val[0]=1.
//    Next cycle flush_out=1 and new_pc_if_out = entry pc; no lane1 commit that cycle.
//  - Flush cycle: all entries invalidated, head=tail=0, count=0, alloc and write-back inputs ignored.
//    flush_out drops the following cycle.
//  - count_next = count + alloc - retired; simultaneous alloc and 2-commit at full/empty must stay exact.
//  - rst_in asserted mid-operation: immediate return to reset state, pending flush dropped.
// TESTING
//  1 Reset, alloc 3 ARITH (ids 0,1,2); write-back id1 then id0 -> cm0/cm1 = ids 0,1 same cycle, id2 later.
//  2 DEPTH=16, FULL_MARGIN=2: 14 allocs, no commit -> full_dp_out=1 at count 14; commit 2 -> full drops.
//  3 Wrap: alloc/retire 20 entries singly -> rob_id_dp_out sequence 0..15,0..3; count never exceeds 16.
//  4 BRANCH at head, val=1, pc=0x100, ARITH ready behind -> flush_out=1, new_pc_if_out=0x100, ARITH not committed, next alloc id 0.
//  5 ALU and LS write-back to id 4 and id 5 same cycle while dispatcher reads rs1=4, rs2=5 -> both rdy=1, forwarded values.
//  6 Two ready STOREs at head -> retire one per cycle; head_id_lsb_out steps 0,1,2; cm*_vld_out stay 0.

Source files
------------

// File: rtl/rob_dual_commit_if.sv
// Reorder-buffer bus bundle: dispatcher allocation and operand lookup, the two CDB write-back
// channels, dual-lane register commit, LSB head release and IF redirect.
//   slave  : the reorder buffer (receives *_in signals, drives *_out signals)
//   master : the surrounding pipeline (or a testbench)
interface rob_dual_commit_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              rdy_in;
  // Dispatcher
  logic              alloc_dp_in;
  logic [2:0]        op_type_dp_in;
  logic [REG_W-1:0]  dest_dp_in;
  logic              full_dp_out;
  logic [IDX_W-1:0]  rob_id_dp_out;
  logic [IDX_W-1:0]  rs1_id_dp_in;
  logic [IDX_W-1:0]  rs2_id_dp_in;
  logic              rs1_rdy_dp_out;
  logic              rs2_rdy_dp_out;
  logic [DATA_W-1:0] rs1_val_dp_out;
  logic [DATA_W-1:0] rs2_val_dp_out;
  // CDB write-back
  logic              wb_a_vld_in;
  logic [IDX_W-1:0]  wb_a_id_in;
  logic [DATA_W-1:0] wb_a_val_in;
  logic [ADDR_W-1:0] wb_a_pc_in;
  logic              wb_ls_vld_in;
  logic [IDX_W-1:0]  wb_ls_id_in;
  logic [DATA_W-1:0] wb_ls_val_in;
  // Commit / LSB / IF
  logic              cm0_vld_out;
  logic              cm1_vld_out;
  logic [REG_W-1:0]  cm0_dest_out;
  logic [REG_W-1:0]  cm1_dest_out;
  logic [DATA_W-1:0] cm0_val_out;
  logic [DATA_W-1:0] cm1_val_out;
  logic [IDX_W-1:0]  cm0_id_out;
  logic [IDX_W-1:0]  cm1_id_out;
  logic [IDX_W-1:0]  head_id_lsb_out;
  logic              flush_out;
  logic [ADDR_W-1:0] new_pc_if_out;

  modport slave (
    input  rdy_in, alloc_dp_in, op_type_dp_in, dest_dp_in, rs1_id_dp_in, rs2_id_dp_in,
           wb_a_vld_in, wb_a_id_in, wb_a_val_in, wb_a_pc_in,
           wb_ls_vld_in, wb_ls_id_in, wb_ls_val_in,
    output full_dp_out, rob_id_dp_out, rs1_rdy_dp_out, rs2_rdy_dp_out,
           rs1_val_dp_out, rs2_val_dp_out,
           cm0_vld_out, cm1_vld_out, cm0_dest_out, cm1_dest_out, cm0_val_out, cm1_val_out,
           cm0_id_out, cm1_id_out, head_id_lsb_out, flush_out, new_pc_if_out
  );

  modport master (
    output rdy_in, alloc_dp_in, op_type_dp_in, dest_dp_in, rs1_id_dp_in, rs2_id_dp_in,
           wb_a_vld_in, wb_a_id_in, wb_a_val_in, wb_a_pc_in,
           wb_ls_vld_in, wb_ls_id_in, wb_ls_val_in,
    input  full_dp_out, rob_id_dp_out, rs1_rdy_dp_out, rs2_rdy_dp_out,
           rs1_val_dp_out, rs2_val_dp_out,
           cm0_vld_out, cm1_vld_out, cm0_dest_out, cm1_dest_out, cm0_val_out, cm1_val_out,
           cm0_id_out, cm1_id_out, head_id_lsb_out, flush_out, new_pc_if_out
  );
endinterface

// File: rtl/rob_dual_commit.sv
// Dual-commit reorder buffer. Circular queue of DEPTH entries allocated in order at the tail,
// completed out of order by the ALU and load/store CDB channels, retired up to two per cycle
// from the head. A retiring JUMP or taken BRANCH raises a one-cycle flush with its pc.
// Ports:
//   clk_in  : clock
//   rst_in  : asynchronous active-high reset
//   rob_if  : rob_dual_commit_if.slave (dispatch, operand lookup, write-back, commit, redirect)
module rob_dual_commit #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned FULL_MARGIN = 2
) (
  input logic              clk_in,
  input logic              rst_in,
  rob_dual_commit_if.slave rob_if
);
  localparam logic [2:0] OpArith  = 3'd0;
  localparam logic [2:0] OpLoad   = 3'd1;
  localparam logic [2:0] OpStore  = 3'd2;
  localparam logic [2:0] OpBranch = 3'd3;
  localparam logic [2:0] OpJump   = 3'd4;
  localparam logic [IDX_W:0] DepthCnt  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] MarginCnt = (IDX_W+1)'(FULL_MARGIN);

  logic [DEPTH-1:0]  r_valid, r_ready;
  logic [2:0]        r_op   [DEPTH];
  logic [REG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_val  [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [IDX_W-1:0]  r_head, r_tail;
  logic [IDX_W:0]    r_count;

  logic              r_cm0_vld, r_cm1_vld, r_flush;
  logic [REG_W-1:0]  r_cm0_dest, r_cm1_dest;
  logic [DATA_W-1:0] r_cm0_val, r_cm1_val;
  logic [IDX_W-1:0]  r_cm0_id, r_cm1_id;
  logic [ADDR_W-1:0] r_new_pc;

  logic [IDX_W-1:0] w_head1;
  logic [2:0]       w_op0, w_op1;
  logic             w_full, w_alloc, w_wb_a, w_wb_ls;
  logic             w_lane0, w_lane1, w_redir0, w_redir1;
  logic [IDX_W:0]   w_retired, w_count_d;
  logic             w_a_hit1, w_a_hit2, w_ls_hit1, w_ls_hit2;

  assign w_head1 = r_head + 1'b1;  // power-of-two depth wraps naturally
  assign w_op0   = r_op[r_head];
  assign w_op1   = r_op[w_head1];

  assign w_full  = (DepthCnt - r_count) <= MarginCnt;
  // Nothing moves during the flush cycle; allocation beyond the full mark is dropped.
  assign w_alloc = rob_if.rdy_in && rob_if.alloc_dp_in && !r_flush && !w_full;
  assign w_wb_a  = rob_if.rdy_in && !r_flush && rob_if.wb_a_vld_in && r_valid[rob_if.wb_a_id_in];
  assign w_wb_ls = rob_if.rdy_in && !r_flush && rob_if.wb_ls_vld_in
                   && r_valid[rob_if.wb_ls_id_in];

  assign w_lane0  = rob_if.rdy_in && !r_flush && r_valid[r_head] && r_ready[r_head];
  assign w_redir0 = (w_op0 == OpJump) || (w_op0 == OpBranch && r_val[r_head][0]);
  // Second lane never retires past a redirect, and the LSB releases one store per cycle.
  assign w_lane1  = w_lane0 && !w_redir0 && r_valid[w_head1] && r_ready[w_head1]
                    && !(w_op0 == OpStore && w_op1 == OpStore);
  assign w_redir1 = (w_op1 == OpJump) || (w_op1 == OpBranch && r_val[w_head1][0]);

  assign w_retired = (IDX_W+1)'(w_lane0) + (IDX_W+1)'(w_lane1);
  assign w_count_d = r_count + (IDX_W+1)'(w_alloc) - w_retired;

  // Operand lookup with same-cycle CDB forwarding; ALU value wins on a double hit.
  assign w_a_hit1  = rob_if.wb_a_vld_in  && (rob_if.wb_a_id_in  == rob_if.rs1_id_dp_in);
  assign w_a_hit2  = rob_if.wb_a_vld_in  && (rob_if.wb_a_id_in  == rob_if.rs2_id_dp_in);
  assign w_ls_hit1 = rob_if.wb_ls_vld_in && (rob_if.wb_ls_id_in == rob_if.rs1_id_dp_in);
  assign w_ls_hit2 = rob_if.wb_ls_vld_in && (rob_if.wb_ls_id_in == rob_if.rs2_id_dp_in);

  assign rob_if.rs1_rdy_dp_out = r_ready[rob_if.rs1_id_dp_in] || w_a_hit1 || w_ls_hit1;
  assign rob_if.rs2_rdy_dp_out = r_ready[rob_if.rs2_id_dp_in] || w_a_hit2 || w_ls_hit2;
  assign rob_if.rs1_val_dp_out = w_a_hit1  ? rob_if.wb_a_val_in  :
                                 w_ls_hit1 ? rob_if.wb_ls_val_in : r_val[rob_if.rs1_id_dp_in];
  assign rob_if.rs2_val_dp_out = w_a_hit2  ? rob_if.wb_a_val_in  :
                                 w_ls_hit2 ? rob_if.wb_ls_val_in : r_val[rob_if.rs2_id_dp_in];

  assign rob_if.full_dp_out     = w_full;
  assign rob_if.rob_id_dp_out   = r_tail;
  assign rob_if.head_id_lsb_out = r_head;
  assign rob_if.cm0_vld_out     = r_cm0_vld;
  assign rob_if.cm1_vld_out     = r_cm1_vld;
  assign rob_if.cm0_dest_out    = r_cm0_dest;
  assign rob_if.cm1_dest_out    = r_cm1_dest;
  assign rob_if.cm0_val_out     = r_cm0_val;
  assign rob_if.cm1_val_out     = r_cm1_val;
  assign rob_if.cm0_id_out      = r_cm0_id;
  assign rob_if.cm1_id_out      = r_cm1_id;
  assign rob_if.flush_out       = r_flush;
  assign rob_if.new_pc_if_out   = r_new_pc;

  // Control state and registered commit/redirect outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid    <= '0;
      r_ready    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_cm0_vld  <= 1'b0;
      r_cm1_vld  <= 1'b0;
      r_cm0_dest <= '0;
      r_cm1_dest <= '0;
      r_cm0_val  <= '0;
      r_cm1_val  <= '0;
      r_cm0_id   <= '0;
      r_cm1_id   <= '0;
      r_flush    <= 1'b0;
      r_new_pc   <= '0;
    end else if (rob_if.rdy_in) begin
      if (r_flush) begin
        r_valid    <= '0;
        r_ready    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_cm0_vld  <= 1'b0;
        r_cm1_vld  <= 1'b0;
        r_cm0_dest <= '0;
        r_cm1_dest <= '0;
        r_cm0_val  <= '0;
        r_cm1_val  <= '0;
        r_cm0_id   <= '0;
        r_cm1_id   <= '0;
        r_flush    <= 1'b0;
        r_new_pc   <= '0;
      end else begin
        if (w_wb_ls) r_ready[rob_if.wb_ls_id_in] <= 1'b1;
        if (w_wb_a)  r_ready[rob_if.wb_a_id_in]  <= 1'b1;
        if (w_lane0) begin
          r_valid[r_head] <= 1'b0;
          r_ready[r_head] <= 1'b0;
        end
        if (w_lane1) begin
          r_valid[w_head1] <= 1'b0;
          r_ready[w_head1] <= 1'b0;
        end
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + 1'b1;
        end
        r_head     <= r_head + IDX_W'(w_retired);
        r_count    <= w_count_d;
        r_cm0_vld  <= w_lane0 && (w_op0 inside {OpArith, OpLoad, OpJump});
        r_cm1_vld  <= w_lane1 && (w_op1 inside {OpArith, OpLoad, OpJump});
        r_cm0_dest <= w_lane0 ? r_dest[r_head]  : '0;
        r_cm1_dest <= w_lane1 ? r_dest[w_head1] : '0;
        r_cm0_val  <= w_lane0 ? r_val[r_head]   : '0;
        r_cm1_val  <= w_lane1 ? r_val[w_head1]  : '0;
        r_cm0_id   <= w_lane0 ? r_head          : '0;
        r_cm1_id   <= w_lane1 ? w_head1         : '0;
        r_flush    <= (w_lane0 && w_redir0) || (w_lane1 && w_redir1);
        r_new_pc   <= (w_lane0 && w_redir0) ? r_pc[r_head]  :
                      (w_lane1 && w_redir1) ? r_pc[w_head1] : '0;
      end
    end
  end

  // Entry payload; validity lives in r_valid, so no reset is needed here.
  always_ff @(posedge clk_in) begin
    if (w_alloc) begin
      r_op[r_tail]   <= rob_if.op_type_dp_in;
      r_dest[r_tail] <= rob_if.dest_dp_in;
      r_val[r_tail]  <= '0;
      r_pc[r_tail]   <= '0;
    end
    if (w_wb_ls && r_op[rob_if.wb_ls_id_in] == OpLoad) begin
      r_val[rob_if.wb_ls_id_in] <= rob_if.wb_ls_val_in;
    end
    if (w_wb_a) begin
      r_val[rob_if.wb_a_id_in] <= rob_if.wb_a_val_in;
      r_pc[rob_if.wb_a_id_in]  <= rob_if.wb_a_pc_in;
    end
  end
endmodule

// File: tb/tb_rob_dual_commit.sv
// Self-checking bench for rob_dual_commit: directed scenarios followed by random traffic,
// all compared against an in-order queue model of the reorder buffer.
module tb_rob_dual_commit;
  localparam int DEPTH = 16, IDX_W = 4, DATA_W = 32, ADDR_W = 32, REG_W = 5, MARGIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_dual_commit_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  rob_dual_commit #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W),
    .FULL_MARGIN(MARGIN)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rob_if (bus)
  );

  // Model: occupied entries in program order, oldest first.
  typedef struct {
    int          id;
    int          op;
    int          dest;
    logic [31:0] val;
    logic [31:0] pc;
    bit          rdy;
  } ent_t;

  ent_t        q[$];
  int          m_head;
  bit          e_flush;
  logic [31:0] e_new_pc;
  bit          e_vld[2];
  int          e_dest[2];
  logic [31:0] e_val[2];
  int          e_id[2];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head   = 0;
    e_flush  = 0;
    e_new_pc = '0;
    for (int i = 0; i < 2; i++) begin
      e_vld[i] = 0; e_dest[i] = 0; e_val[i] = '0; e_id[i] = 0;
    end
  endtask

  task automatic check_operand(input string tag, input int id, input logic obs_rdy,
                               input logic [31:0] obs_val);
    bit          rdy;
    logic [31:0] val;
    rdy = 0;
    val = '0;
    foreach (q[i]) if (q[i].id == id && q[i].rdy) begin rdy = 1; val = q[i].val; end
    if (bus.wb_ls_vld_in && int'(bus.wb_ls_id_in) == id) begin rdy = 1; val = bus.wb_ls_val_in; end
    if (bus.wb_a_vld_in && int'(bus.wb_a_id_in) == id) begin rdy = 1; val = bus.wb_a_val_in; end
    check({tag, "_rdy"}, obs_rdy, rdy);
    if (rdy) check({tag, "_val"}, obs_val, val);
  endtask

  task automatic check_outputs();
    check("full", bus.full_dp_out, (DEPTH - q.size()) <= MARGIN);
    check("rob_id", bus.rob_id_dp_out, (m_head + q.size()) % DEPTH);
    check("head_id", bus.head_id_lsb_out, m_head);
    check_operand("rs1", int'(bus.rs1_id_dp_in), bus.rs1_rdy_dp_out, bus.rs1_val_dp_out);
    check_operand("rs2", int'(bus.rs2_id_dp_in), bus.rs2_rdy_dp_out, bus.rs2_val_dp_out);
    check("flush", bus.flush_out, e_flush);
    if (e_flush) check("new_pc", bus.new_pc_if_out, e_new_pc);
    check("cm0_vld", bus.cm0_vld_out, e_vld[0]);
    if (e_vld[0]) begin
      check("cm0_dest", bus.cm0_dest_out, e_dest[0]);
      check("cm0_val", bus.cm0_val_out, e_val[0]);
      check("cm0_id", bus.cm0_id_out, e_id[0]);
    end
    check("cm1_vld", bus.cm1_vld_out, e_vld[1]);
    if (e_vld[1]) begin
      check("cm1_dest", bus.cm1_dest_out, e_dest[1]);
      check("cm1_val", bus.cm1_val_out, e_val[1]);
      check("cm1_id", bus.cm1_id_out, e_id[1]);
    end
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    int   sz, tail, n;
    bit   redir;
    ent_t c[2];
    if (!bus.rdy_in) return;
    e_vld[0] = 0;
    e_vld[1] = 0;
    if (e_flush) begin
      q.delete();
      m_head  = 0;
      e_flush = 0;
      return;
    end
    sz    = q.size();
    tail  = (m_head + sz) % DEPTH;
    n     = 0;
    redir = 0;
    // Retire ready entries from the front (readiness as of the start of the cycle).
    while (n < 2 && q.size() > 0 && q[0].rdy && !redir) begin
      if (n == 1 && c[0].op == 2 && q[0].op == 2) break;
      c[n]      = q.pop_front();
      redir     = (c[n].op == 4) || (c[n].op == 3 && c[n].val[0]);
      e_vld[n]  = (c[n].op == 0) || (c[n].op == 1) || (c[n].op == 4);
      e_dest[n] = c[n].dest;
      e_val[n]  = c[n].val;
      e_id[n]   = c[n].id;
      if (redir) e_new_pc = c[n].pc;
      n++;
    end
    e_flush = redir;
    foreach (q[i]) begin
      if (bus.wb_ls_vld_in && int'(bus.wb_ls_id_in) == q[i].id) begin
        q[i].rdy = 1;
        if (q[i].op == 1) q[i].val = bus.wb_ls_val_in;
      end
      if (bus.wb_a_vld_in && int'(bus.wb_a_id_in) == q[i].id) begin
        q[i].rdy = 1;
        q[i].val = bus.wb_a_val_in;
        q[i].pc  = bus.wb_a_pc_in;
      end
    end
    if (bus.alloc_dp_in && (DEPTH - sz) > MARGIN)
      q.push_back('{id: tail, op: int'(bus.op_type_dp_in), dest: int'(bus.dest_dp_in),
                    val: 32'h0, pc: 32'h0, rdy: 1'b0});
    m_head = (m_head + n) % DEPTH;
  endtask

  task automatic idle();
    bus.rdy_in        = 1'b1;
    bus.alloc_dp_in   = 1'b0;
    bus.op_type_dp_in = 3'd0;
    bus.dest_dp_in    = '0;
    bus.rs1_id_dp_in  = '0;
    bus.rs2_id_dp_in  = '0;
    bus.wb_a_vld_in   = 1'b0;
    bus.wb_a_id_in    = '0;
    bus.wb_a_val_in   = '0;
    bus.wb_a_pc_in    = '0;
    bus.wb_ls_vld_in  = 1'b0;
    bus.wb_ls_id_in   = '0;
    bus.wb_ls_val_in  = '0;
  endtask

  // Inputs are set just after a falling edge; check, then let one rising edge pass.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic alloc_op(input logic [2:0] op, input logic [4:0] dest);
    idle();
    bus.alloc_dp_in   = 1'b1;
    bus.op_type_dp_in = op;
    bus.dest_dp_in    = dest;
    tick();
  endtask

  task automatic wb_alu(input int id, input logic [31:0] val, input logic [31:0] pc);
    idle();
    bus.wb_a_vld_in = 1'b1;
    bus.wb_a_id_in  = 4'(id);
    bus.wb_a_val_in = val;
    bus.wb_a_pc_in  = pc;
    tick();
  endtask

  function automatic logic [3:0] pick_id();
    if (q.size() > 0 && $urandom_range(0, 7) != 0) return 4'(q[$urandom_range(0, q.size() - 1)].id);
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    int r;
    model_reset();
    idle();

    // Reset state, then three ARITH completing out of order.
    do_reset();
    check("t1_rst_rob_id", bus.rob_id_dp_out, 0);
    check("t1_rst_flush", bus.flush_out, 0);
    check("t1_rst_cm0", bus.cm0_vld_out, 0);
    check("t1_rst_full", bus.full_dp_out, 0);
    for (int i = 0; i < 3; i++) begin
      check("t1_alloc_id", bus.rob_id_dp_out, i);
      alloc_op(3'd0, 5'(i + 1));
    end
    wb_alu(1, 32'h11, 32'h0);
    wb_alu(0, 32'h10, 32'h0);
    idle();
    tick();
    check("t1_cm0_vld", bus.cm0_vld_out, 1);
    check("t1_cm0_id", bus.cm0_id_out, 0);
    check("t1_cm1_vld", bus.cm1_vld_out, 1);
    check("t1_cm1_id", bus.cm1_id_out, 1);
    check("t1_cm1_val", bus.cm1_val_out, 32'h11);
    wb_alu(2, 32'h12, 32'h0);
    idle();
    tick();
    check("t1_cm0_id2", bus.cm0_id_out, 2);
    check("t1_cm1_vld2", bus.cm1_vld_out, 0);

    // Full threshold at 14 entries; an extra alloc is ignored; dual commit releases it.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      check("t2_not_full", bus.full_dp_out, 0);
      alloc_op(3'd0, 5'd1);
    end
    check("t2_full", bus.full_dp_out, 1);
    alloc_op(3'd0, 5'd1);
    check("t2_ignored_alloc", bus.rob_id_dp_out, 14);
    idle();
    bus.wb_a_vld_in  = 1'b1; bus.wb_a_id_in  = 4'd0; bus.wb_a_val_in  = 32'h1;
    bus.wb_ls_vld_in = 1'b1; bus.wb_ls_id_in = 4'd1; bus.wb_ls_val_in = 32'h2;
    tick();
    idle();
    tick();
    check("t2_full_drops", bus.full_dp_out, 0);

    // Wrap-around: 20 single alloc/retire rounds.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check("t3_rob_id", bus.rob_id_dp_out, i % 16);
      alloc_op(3'd0, 5'(i));
      wb_alu(i % 16, 32'(i), 32'h0);
      idle();
      tick();
    end

    // Taken branch at head with a ready ARITH behind it.
    do_reset();
    alloc_op(3'd3, 5'd0);
    alloc_op(3'd0, 5'd3);
    idle();
    bus.wb_ls_vld_in = 1'b1; bus.wb_ls_id_in = 4'd1;
    tick();
    wb_alu(0, 32'h1, 32'h100);
    idle();
    tick();
    check("t4_flush", bus.flush_out, 1);
    check("t4_new_pc", bus.new_pc_if_out, 32'h100);
    check("t4_cm1_vld", bus.cm1_vld_out, 0);
    idle();
    bus.alloc_dp_in = 1'b1;
    tick();
    check("t4_flush_drop", bus.flush_out, 0);
    check("t4_arith_dropped", bus.cm0_vld_out, 0);
    check("t4_next_id", bus.rob_id_dp_out, 0);

    // Both CDB channels forward to the dispatcher in the same cycle.
    for (int i = 0; i < 6; i++) alloc_op(3'd0, 5'd7);
    idle();
    bus.wb_a_vld_in  = 1'b1; bus.wb_a_id_in  = 4'd4; bus.wb_a_val_in  = 32'hAAAA5555;
    bus.wb_ls_vld_in = 1'b1; bus.wb_ls_id_in = 4'd5; bus.wb_ls_val_in = 32'h5555AAAA;
    bus.rs1_id_dp_in = 4'd4;
    bus.rs2_id_dp_in = 4'd5;
    #1;
    check("t5_rs1_rdy", bus.rs1_rdy_dp_out, 1);
    check("t5_rs1_val", bus.rs1_val_dp_out, 32'hAAAA5555);
    check("t5_rs2_rdy", bus.rs2_rdy_dp_out, 1);
    check("t5_rs2_val", bus.rs2_val_dp_out, 32'h5555AAAA);
    tick();

    // Two ready STOREs retire one per cycle, silently.
    do_reset();
    alloc_op(3'd2, 5'd0);
    alloc_op(3'd2, 5'd0);
    idle();
    bus.wb_a_vld_in  = 1'b1; bus.wb_a_id_in  = 4'd0;
    bus.wb_ls_vld_in = 1'b1; bus.wb_ls_id_in = 4'd1;
    tick();
    check("t6_head0", bus.head_id_lsb_out, 0);
    idle();
    tick();
    check("t6_head1", bus.head_id_lsb_out, 1);
    check("t6_cm0_silent", bus.cm0_vld_out, 0);
    check("t6_cm1_silent", bus.cm1_vld_out, 0);
    idle();
    tick();
    check("t6_head2", bus.head_id_lsb_out, 2);
    check("t6_cm0_silent2", bus.cm0_vld_out, 0);

    // Random traffic against the model, with occasional mid-run resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      idle();
      bus.rdy_in      = ($urandom_range(0, 15) != 0);
      bus.alloc_dp_in = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 19);
      bus.op_type_dp_in = (r < 8) ? 3'd0 : (r < 12) ? 3'd1 : (r < 16) ? 3'd2 : (r < 19) ? 3'd3 : 3'd4;
      bus.dest_dp_in    = 5'($urandom);
      bus.wb_a_vld_in   = 1'($urandom_range(0, 1));
      bus.wb_a_id_in    = pick_id();
      bus.wb_a_val_in   = $urandom;
      bus.wb_a_pc_in    = $urandom;
      bus.wb_ls_vld_in  = 1'($urandom_range(0, 1));
      bus.wb_ls_id_in   = pick_id();
      bus.wb_ls_val_in  = $urandom;
      bus.rs1_id_dp_in  = ($urandom_range(0, 3) == 0) ? bus.wb_a_id_in : 4'($urandom);
      bus.rs2_id_dp_in  = ($urandom_range(0, 3) == 0) ? bus.wb_ls_id_in : 4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
